// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: kernel geometry, pixel/window types and the
// window-generator control states.
package cnn_pkg;

  localparam int KERNEL_SIZE = 3;
  localparam int PE_ARR_SIZE = KERNEL_SIZE * KERNEL_SIZE;
  localparam int INPUT_WIDTH = 8;

  typedef logic signed [INPUT_WIDTH-1:0] pixel_t;
  typedef pixel_t window_t [PE_ARR_SIZE];

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/ifm_window_gen_if.sv
// Pixel-in / window-out bundle between the pixel source, the window
// generator and the PE array.
interface ifm_window_gen_if #(
  parameter int INPUT_WIDTH = 8
);

  logic                          start;
  logic                          pix_valid;
  logic signed [INPUT_WIDTH-1:0] pix_data;
  logic                          pix_ready;
  logic                          win_valid;
  logic signed [INPUT_WIDTH-1:0] ifm_window [cnn_pkg::PE_ARR_SIZE];
  logic                          busy;
  logic                          frame_done;

  modport master (
    output start, pix_valid, pix_data,
    input  pix_ready, win_valid, ifm_window, busy, frame_done
  );

  modport slave (
    input  start, pix_valid, pix_data,
    output pix_ready, win_valid, ifm_window, busy, frame_done
  );

endinterface

// File: rtl/ifm_window_gen_line_buffer.sv
// One image row of pixels, addressed by column. Read is combinational so the
// old value at a column is seen in the same cycle it is overwritten.
module line_buffer #(
  parameter int INPUT_WIDTH = 8,
  parameter int IMG_W       = 32,
  localparam int AW         = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 addr,
  input  logic signed [INPUT_WIDTH-1:0] din,
  output logic signed [INPUT_WIDTH-1:0] dout
);

  logic signed [INPUT_WIDTH-1:0] mem [IMG_W];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= din;
  end

endmodule

// File: rtl/ifm_window_gen.sv
// Streaming 3x3 valid-convolution window generator feeding the 9-lane PE array.
// Two line buffers hold rows r-1/r-2; a 3x3 shift register assembles the window.
module ifm_window_gen #(
  parameter int INPUT_WIDTH = 8,
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32
) (
  input logic            clk,
  input logic            rst_n,
  ifm_window_gen_if.slave bus
);

  import cnn_pkg::*;

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_t                        state_p0, state_nx;
  logic [CW-1:0]                 col_p0;
  logic [RW-1:0]                 row_p0;
  logic                          xfer, last_col, last_pix, win_hit;
  logic signed [INPUT_WIDTH-1:0] lb0_q, lb1_q;
  logic signed [INPUT_WIDTH-1:0] sr_p0 [PE_ARR_SIZE];
  logic signed [INPUT_WIDTH-1:0] sr_nx [PE_ARR_SIZE];

  assign xfer     = bus.pix_valid && bus.pix_ready;
  assign last_col = (col_p0 == CW'(IMG_W - 1));
  assign last_pix = last_col && (row_p0 == RW'(IMG_H - 1));
  assign win_hit  = xfer && (row_p0 >= RW'(2)) && (col_p0 >= CW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p0 <= IDLE;
    else        state_p0 <= state_nx;
  end

  always_comb begin
    state_nx       = state_p0;
    bus.pix_ready  = 1'b0;
    bus.busy       = 1'b0;
    bus.frame_done = 1'b0;
    case (state_p0)
      IDLE: if (bus.start) state_nx = RUN;
      RUN: begin
        bus.pix_ready = 1'b1;
        bus.busy      = 1'b1;
        if (xfer && last_pix) state_nx = DONE;
      end
      DONE: begin
        bus.busy       = 1'b1;
        bus.frame_done = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (state_p0 == IDLE && bus.start) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (xfer) begin
      if (last_col) begin
        col_p0 <= '0;
        row_p0 <= (row_p0 == RW'(IMG_H - 1)) ? '0 : row_p0 + RW'(1);
      end else begin
        col_p0 <= col_p0 + CW'(1);
      end
    end
  end

  // Stage p0: line buffers shift the column vertically (lb1 -> lb0, pix -> lb1)
  line_buffer #(.INPUT_WIDTH(INPUT_WIDTH), .IMG_W(IMG_W)) u_lb1 (
    .clk(clk), .wr_en(xfer), .addr(col_p0), .din(bus.pix_data), .dout(lb1_q)
  );

  line_buffer #(.INPUT_WIDTH(INPUT_WIDTH), .IMG_W(IMG_W)) u_lb0 (
    .clk(clk), .wr_en(xfer), .addr(col_p0), .din(lb1_q), .dout(lb0_q)
  );

  always_comb begin
    for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
      sr_nx[3*ky]     = sr_p0[3*ky + 1];
      sr_nx[3*ky + 1] = sr_p0[3*ky + 2];
    end
    sr_nx[2] = lb0_q;
    sr_nx[5] = lb1_q;
    sr_nx[8] = bus.pix_data;
  end

  always_ff @(posedge clk) begin
    if (xfer) sr_p0 <= sr_nx;
  end

  // Stage p1: registered window; holds between strobes so the PE array sees a stable load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.win_valid <= 1'b0;
      for (int i = 0; i < PE_ARR_SIZE; i++) bus.ifm_window[i] <= '0;
    end else begin
      bus.win_valid <= win_hit;
      if (win_hit) begin
        for (int i = 0; i < PE_ARR_SIZE; i++) bus.ifm_window[i] <= sr_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_ifm_window_gen.sv
// Randomized directed bench for ifm_window_gen on a 5x5 image; expected
// windows are cut straight out of the image array the bench sends.
module tb_ifm_window_gen;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int IW = 8;

  typedef int win9_t [9];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifm_window_gen_if #(.INPUT_WIDTH(IW)) bus ();

  ifm_window_gen #(.INPUT_WIDTH(IW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int    checks   = 0;
  int    failures = 0;
  int    img [W*H];
  win9_t got [$];
  int    wins;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int pick(input int mode, input int k);
    if (mode == 0) return k;
    if (k == 12) return -128;
    if (k == 18) return 127;
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // window whose bottom-right pixel is raster index k
  function automatic void model_win(input int k, output win9_t w);
    int r, c;
    r = k / W;
    c = k % W;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        w[3*ky + kx] = img[(r - 2 + ky) * W + (c - 2 + kx)];
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pix_ready"}, bus.pix_ready, 0);
    chk({tag, "_win_valid"}, bus.win_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    for (int i = 0; i < 9; i++) chk({tag, "_window"}, bus.ifm_window[i], 0);
  endtask

  task automatic run_frame(input int bubble_pct, input int stray_k, input int abort_k, input int mode);
    int    k = 0;
    int    cyc = 0;
    bit    exp_wv = 0;
    bit    exp_done = 0;
    bit    fin = 0;
    bit    v;
    win9_t ew;
    win9_t cur;
    wins = 0;
    got.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.pix_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    while (!fin && cyc <= 500) begin
      if (cyc > 0) begin
        chk("win_valid", bus.win_valid, exp_wv);
        chk("frame_done", bus.frame_done, exp_done);
        if (bus.win_valid === 1'b1 && exp_wv) begin
          for (int i = 0; i < 9; i++) begin
            chk("win_pixel", bus.ifm_window[i], ew[i]);
            cur[i] = int'(bus.ifm_window[i]);
          end
          got.push_back(cur);
          wins++;
        end
      end
      if (exp_done) begin
        bus.pix_valid = 1'b0;
        fin = 1;
      end else if (abort_k >= 0 && k == abort_k + 1) begin
        bus.pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("abort");
        fin = 1;
      end else begin
        chk("pix_ready_run", bus.pix_ready, 1);
        chk("busy_run", bus.busy, 1);
        v = (int'($urandom_range(0, 99)) >= bubble_pct);
        bus.start = (k == stray_k);
        bus.pix_valid = v;
        if (v) begin
          img[k] = pick(mode, k);
          bus.pix_data = IW'(img[k]);
          exp_wv = ((k / W) >= 2) && ((k % W) >= 2);
          if (exp_wv) model_win(k, ew);
          exp_done = (k == W*H - 1);
          k++;
        end else begin
          bus.pix_data = IW'($urandom);
          exp_wv = 0;
          exp_done = 0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0;
    chk("frame_in_budget", cyc <= 500, 1);
    if (abort_k >= 0) begin
      repeat (2) @(negedge clk);
      chk("abort_still_idle", bus.busy, 0);
      rst_n = 1'b1;
    end else begin
      @(negedge clk);
      chk("post_busy", bus.busy, 0);
      chk("post_frame_done", bus.frame_done, 0);
      chk("post_win_valid", bus.win_valid, 0);
      chk("post_pix_ready", bus.pix_ready, 0);
    end
  endtask

  task automatic check_basic(input string tag);
    win9_t first_w, row_w, last_w;
    first_w = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    row_w   = '{5, 6, 7, 10, 11, 12, 15, 16, 17};
    last_w  = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    chk({tag, "_win_count"}, wins, 9);
    if (got.size() > 8) begin
      for (int i = 0; i < 9; i++) begin
        chk({tag, "_first_win"}, got[0][i], first_w[i]);
        chk({tag, "_row_win"}, got[3][i], row_w[i]);
        chk({tag, "_last_win"}, got[8][i], last_w[i]);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    bus.pix_valid = 1'b1;
    bus.pix_data = 8'sd99;
    repeat (4) begin
      @(negedge clk);
      chk("idle_pix_ready", bus.pix_ready, 0);
      chk("idle_win_valid", bus.win_valid, 0);
      chk("idle_busy", bus.busy, 0);
    end
    bus.pix_valid = 1'b0;

    run_frame(0, -1, -1, 0);
    check_basic("basic");

    run_frame(50, 7, -1, 0);
    check_basic("bubble");

    run_frame(0, -1, 13, 0);
    chk("abort_win_count", wins, 2);

    run_frame(0, -1, -1, 0);
    check_basic("after_reset");

    run_frame(30, -1, -1, 1);
    chk("signed_win_count", wins, 9);
    if (got.size() > 4) begin
      chk("signed_min", got[0][8], -128);
      chk("signed_max", got[4][8], 127);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
